// File: rtl/wb_wport_arbiter.sv
// wb_wport_arbiter: shares one register-file write port between the in-order
// pipeline writeback and a 2-entry buffer of long-latency (aux) results.
// The pipe normally wins. A buffered aux entry can lose arbitration for at most
// STARVE_MAX consecutive cycles before it is forced through.
// The write port and the trace PC are registered. The trace enable, number and
// data outputs are copies of the registered write port.
module wb_wport_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_dest,
  input  logic [31:0] pipe_wdata,
  input  logic [31:0] pipe_pc,
  output logic        pipe_ready,
  input  logic        aux_valid,
  input  logic [4:0]  aux_dest,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        aux_pending
);

  // The starvation counter must be wide enough to hold STARVE_MAX itself.
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  // Aux FIFO storage and state. The pointers are 1 bit wide, so they wrap modulo 2.
  logic [4:0]    r_fifo_dest [0:1];
  logic [31:0]   r_fifo_data [0:1];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;
  logic [SW-1:0] r_starve;

  // Registered write port and trace PC.
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;
  logic [31:0]   r_wb_pc;

  // Combinational arbitration and next-state values.
  logic          w_aux_ready;
  logic          w_fifo_nonempty;
  logic          w_aux_sel;
  logic          w_push;
  logic          w_pop;
  logic          w_pipe_acc;
  logic [4:0]    w_head_dest;
  logic [31:0]   w_head_data;
  logic [1:0]    w_count_nxt;
  logic [SW-1:0] w_starve_nxt;

  // aux_ready looks only at the registered count. A pop in the same cycle does
  // not free a slot for a push.
  assign w_aux_ready     = (r_count != 2'd2);
  assign w_fifo_nonempty = (r_count != 2'd0);
  assign w_push          = aux_valid && w_aux_ready;
  assign w_pop           = w_aux_sel;
  assign w_pipe_acc      = pipe_valid && !w_aux_sel;
  assign w_head_dest     = r_fifo_dest[r_rptr];
  assign w_head_data     = r_fifo_data[r_rptr];

  // Arbitration: aux wins when the pipe is idle or the head has starved long enough.
  always_comb begin
    w_aux_sel = 1'b0;
    if (w_fifo_nonempty) begin
      if (!pipe_valid || (r_starve == STARVE_LIM)) begin
        w_aux_sel = 1'b1;
      end else begin
        w_aux_sel = 1'b0;
      end
    end else begin
      w_aux_sel = 1'b0;
    end
  end

  // Occupancy update. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Starvation counter: cleared when the FIFO is empty or on a pop. Otherwise it
  // counts lost cycles and saturates at STARVE_MAX.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!w_fifo_nonempty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve != STARVE_LIM) begin
      w_starve_nxt = r_starve + STARVE_ONE;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // FIFO pointers, occupancy, storage and starvation state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= 2'd0;
      r_starve       <= '0;
      r_fifo_dest[0] <= 5'd0;
      r_fifo_dest[1] <= 5'd0;
      r_fifo_data[0] <= 32'd0;
      r_fifo_data[1] <= 32'd0;
    end else begin
      if (w_push) begin
        r_fifo_dest[r_wptr] <= aux_dest;
        r_fifo_data[r_wptr] <= aux_wdata;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Register the write port. The winner's write is issued here. rf_we drops to
  // 0 when nothing is issued, and address, data and PC keep their values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_wb_pc    <= 32'd0;
    end else if (w_pop) begin
      r_rf_we    <= (w_head_dest != 5'd0);
      r_rf_waddr <= w_head_dest;
      r_rf_wdata <= w_head_data;
      r_wb_pc    <= 32'd0;
    end else if (w_pipe_acc) begin
      r_rf_we    <= pipe_we && (pipe_dest != 5'd0);
      r_rf_waddr <= pipe_dest;
      r_rf_wdata <= pipe_wdata;
      r_wb_pc    <= pipe_pc;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign pipe_ready        = !w_aux_sel;
  assign aux_ready         = w_aux_ready;
  assign aux_pending       = w_fifo_nonempty;
  assign rf_we             = r_rf_we;
  assign rf_waddr          = r_rf_waddr;
  assign rf_wdata          = r_rf_wdata;
  assign debug_wb_pc       = r_wb_pc;
  assign debug_wb_rf_wen   = {4{r_rf_we}};
  assign debug_wb_rf_wnum  = r_rf_waddr;
  assign debug_wb_rf_wdata = r_rf_wdata;

endmodule

// File: doc/wb_wport_arbiter.md
WB_WPORT_ARBITER -- requirements
Module: wb_wport_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive cycles a pending aux entry may lose arbitration.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port pipe_valid, input, 1 bit: the pipeline writeback request is valid.
REQ-005 SHALL have port pipe_we, input, 1 bit: the pipeline request writes the register file.
REQ-006 SHALL have port pipe_dest, input, 5 bits: the pipeline destination register.
REQ-007 SHALL have port pipe_wdata, input, 32 bits: the pipeline write data.
REQ-008 SHALL have port pipe_pc, input, 32 bits: the PC of the pipeline instruction.
REQ-009 SHALL have port pipe_ready, output, 1 bit: the pipeline request is accepted this cycle.
REQ-010 SHALL have port aux_valid, input, 1 bit: a long-latency unit result is valid.
REQ-011 SHALL have port aux_dest, input, 5 bits: the aux destination register.
REQ-012 SHALL have port aux_wdata, input, 32 bits: the aux write data.
REQ-013 SHALL have port aux_ready, output, 1 bit: the aux result is accepted into the buffer.
REQ-014 SHALL have outputs rf_we (1 bit), rf_waddr (5 bits) and rf_wdata (32 bits): the registered register-file write port.
REQ-015 SHALL have outputs debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (5) and debug_wb_rf_wdata (32): the trace port.
REQ-016 SHALL have port aux_pending, output, 1 bit: the aux buffer is non-empty.

Function
REQ-017 SHALL hold aux results in a 2-entry FIFO; push occurs on aux_valid && aux_ready.
REQ-018 SHALL drive aux_ready = (count != 2), derived from registered count only; there is no same-cycle pop pass-through.
REQ-019 SHALL route every aux result through the FIFO, even when the FIFO is empty; minimum aux-to-rf_we latency is 2 cycles.
REQ-020 SHALL select aux (aux_sel) when the FIFO is non-empty && (!pipe_valid || starve_cnt == STARVE_MAX); otherwise pipe wins.
REQ-021 SHALL drive pipe_ready = !aux_sel, combinationally.
REQ-022 SHALL pop the FIFO head exactly when aux_sel is asserted.
REQ-023 SHALL clear starve_cnt when the FIFO is empty or on a pop, and otherwise increment it, saturating at STARVE_MAX, when the FIFO is non-empty and not popped.
REQ-024 SHALL, on pipe acceptance (pipe_valid && pipe_ready), register next cycle: rf_we = pipe_we && (pipe_dest != 0), rf_waddr = pipe_dest, rf_wdata = pipe_wdata, debug_wb_pc = pipe_pc.
REQ-025 SHALL, on pop, register next cycle: rf_we = (head dest != 0), rf_waddr = head dest, rf_wdata = head data, debug_wb_pc = 0.
REQ-026 SHALL, in a cycle with neither pipe acceptance nor pop, register rf_we = 0 and hold rf_waddr, rf_wdata and debug_wb_pc.
REQ-027 SHALL drive debug_wb_rf_wen = {4{rf_we}}, debug_wb_rf_wnum = rf_waddr and debug_wb_rf_wdata = rf_wdata.
REQ-028 SHALL, on a simultaneous push and pop, leave count unchanged and preserve FIFO order; at count 2, push is blocked by REQ-018.
REQ-029 SHALL wrap the FIFO read and write pointers modulo 2.
REQ-030 SHALL drive aux_pending = (count != 0).
REQ-031 SHALL never produce more than one rf write per cycle.
REQ-032 SHALL never lose or duplicate an aux entry.

Reset
REQ-033 SHALL, while reset is high and independent of clk, clear count, pointers, starve_cnt, rf_we, rf_waddr, rf_wdata and all debug outputs to 0.
REQ-034 SHALL, on reset mid-operation, discard buffered aux entries; aux_ready is 1 and pipe_ready equals 1 during and after reset.

Verification
REQ-035 SHALL verify pipe-only operation: pipe_valid=1, we=1, dest=5, data=0x1234, pc=0xBFC00000 -> next cycle rf_we=1, waddr=5, wdata=0x1234, debug_wb_pc=0xBFC00000, debug_wb_rf_wen=0xF.
REQ-036 SHALL verify aux on an idle pipe: aux_valid one cycle, dest=7, data=0xAA, pipe_valid=0 -> rf_we=1, waddr=7 exactly 2 cycles later, debug_wb_pc=0.
REQ-037 SHALL verify starvation: FIFO holds 1 entry, pipe_valid=1 continuously, STARVE_MAX=4 -> pipe_ready=0 in exactly the 5th cycle after push, aux written next cycle, pipe resumes.
REQ-038 SHALL verify full/back-pressure: 3 consecutive aux_valid with pipe busy -> aux_ready=0 after 2 pushes; the third entry is accepted only after a pop; output order is 1, 2, 3.
REQ-039 SHALL verify r0 suppression: pipe dest=0 with we=1 -> rf_we=0, and debug_wb_pc still updates.
REQ-040 SHALL verify asynchronous reset: assert reset between clock edges with 2 entries buffered -> rf_we=0, aux_pending=0 and aux_ready=1 immediately; no stale writes occur after release.
